// File: rtl/sat_mode_ctrl.sv
// Saturation display mode controller: chooses raw, saturated, split-screen or
// black output per pixel, with mode changes deferred to frame boundaries.
module sat_mode_ctrl #(
  parameter int SPLIT_X     = 640,
  parameter int AUTO_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_raw,
  input  logic [15:0] in_dst,
  input  logic        in_de,
  input  logic        in_vs,
  input  logic        req_valid,
  input  logic [1:0]  req_mode,
  output logic        req_ready,
  input  logic        auto_en,
  output logic [15:0] out_data,
  output logic        out_de,
  output logic        out_vs,
  output logic [1:0]  mode_cur,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] SPLIT_COL = 12'(SPLIT_X);
  localparam logic [7:0]  AUTO_LIM  = 8'(AUTO_FRAMES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t      state_q;
  logic [1:0]  mode_pend_q;
  logic [1:0]  mode_cur_q;
  logic [15:0] frame_cnt_q;
  logic [7:0]  auto_cnt_q;
  logic [11:0] col_q;
  logic        vs_prev_q;
  logic [15:0] out_data_q;
  logic        out_de_q;
  logic        out_vs_q;

  logic        vs_rise_d;
  logic        auto_hit_d;
  logic [15:0] out_data_d;

  always_comb begin
    vs_rise_d  = in_vs & ~vs_prev_q;
    auto_hit_d = ((auto_cnt_q + 8'd1) >= AUTO_LIM);
    out_data_d = 16'h0000;
    if (in_de) begin
      case (mode_cur_q)
        2'd0:    out_data_d = in_raw;
        2'd1:    out_data_d = in_dst;
        2'd2:    out_data_d = (col_q < SPLIT_COL) ? in_dst : in_raw;
        default: out_data_d = 16'h0000;
      endcase
    end else begin
      out_data_d = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_pend_q <= 2'd0;
      mode_cur_q  <= 2'd1;
      frame_cnt_q <= 16'd0;
      auto_cnt_q  <= 8'd0;
      col_q       <= 12'd0;
      vs_prev_q   <= 1'b0;
      out_data_q  <= 16'h0000;
      out_de_q    <= 1'b0;
      out_vs_q    <= 1'b0;
    end else begin
      vs_prev_q  <= in_vs;
      out_data_q <= out_data_d;
      out_de_q   <= in_de;
      out_vs_q   <= in_vs;
      if (vs_rise_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (in_de) begin
        if (col_q != 12'hFFF) begin
          col_q <= col_q + 12'd1;
        end
      end else begin
        col_q <= 12'd0;
      end
      case (state_q)
        ST_IDLE: begin
          // A request taken on a vs edge only commits at the following edge
          if (req_valid) begin
            mode_pend_q <= req_mode;
            state_q     <= ST_PEND;
          end
          if (!auto_en) begin
            auto_cnt_q <= 8'd0;
          end else if (vs_rise_d) begin
            if (auto_hit_d) begin
              auto_cnt_q <= 8'd0;
              mode_cur_q <= mode_cur_q + 2'd1;
            end else begin
              auto_cnt_q <= auto_cnt_q + 8'd1;
            end
          end
        end
        ST_PEND: begin
          // Committing request overrides any auto step due at this edge
          if (vs_rise_d) begin
            mode_cur_q <= mode_pend_q;
            state_q    <= ST_IDLE;
            auto_cnt_q <= 8'd0;
          end else if (!auto_en) begin
            auto_cnt_q <= 8'd0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign out_data  = out_data_q;
  assign out_de    = out_de_q;
  assign out_vs    = out_vs_q;
  assign mode_cur  = mode_cur_q;
  assign frame_cnt = frame_cnt_q;

endmodule
